// File: rtl/counter_monitor.sv
// Passive checker for an up/down counter: predicts each next count from the
// previous sample and its controls, records the first mismatch and keeps statistics.
module counter_monitor #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8,
  parameter int CHK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check_en,
  input  logic                 clear,
  input  logic                 mon_rst,
  input  logic                 mon_enable,
  input  logic                 mon_dir,
  input  logic [WIDTH-1:0]     mon_count,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [WIDTH-1:0]     exp_at_fail,
  output logic [WIDTH-1:0]     act_at_fail,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [CHK_CNT_W-1:0] chk_count
);

  typedef enum logic [1:0] {IDLE, PRIME, CHECK, FAULT} state_e;
  typedef struct packed {
    logic rst;
    logic enable;
    logic dir;
  } ctl_t;

  state_e               state_q, state_d;
  ctl_t                 ctl_q;
  logic [WIDTH-1:0]     cnt_q;
  logic                 err_q, err_d;
  logic [2:0]           code_q, code_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [WIDTH-1:0]     act_q, act_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CHK_CNT_W-1:0] ccnt_q, ccnt_d;

  logic [WIDTH-1:0]     pred;
  logic [2:0]           pred_code;
  logic                 mismatch;
  logic                 active;

  // Prediction uses the controls the counter saw on the edge that produced mon_count.
  always_comb begin
    pred      = cnt_q;
    pred_code = 3'd2;
    if (ctl_q.rst) begin
      pred      = '0;
      pred_code = 3'd1;
    end else if (!ctl_q.enable) begin
      pred      = cnt_q;
      pred_code = 3'd2;
    end else if (ctl_q.dir) begin
      pred      = cnt_q + WIDTH'(1);
      pred_code = 3'd3;
    end else begin
      pred      = cnt_q - WIDTH'(1);
      pred_code = 3'd4;
    end
  end

  assign mismatch = (pred != mon_count);
  assign active   = check_en && (state_q == CHECK || state_q == FAULT);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    code_d  = code_q;
    exp_d   = exp_q;
    act_d   = act_q;
    ecnt_d  = ecnt_q;
    ccnt_d  = ccnt_q;
    if (clear) begin
      // clear wins over any mismatch seen on the same edge
      state_d = IDLE;
      err_d   = 1'b0;
      code_d  = '0;
      exp_d   = '0;
      act_d   = '0;
      ecnt_d  = '0;
      ccnt_d  = '0;
    end else begin
      if (!check_en) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE:    state_d = PRIME;
          PRIME:   state_d = CHECK;
          CHECK:   state_d = mismatch ? FAULT : CHECK;
          FAULT:   state_d = FAULT;
          default: state_d = IDLE;
        endcase
      end
      if (active) begin
        if (ccnt_q != '1) ccnt_d = ccnt_q + CHK_CNT_W'(1);
        if (mismatch) begin
          if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_CNT_W'(1);
          if (!err_q) begin
            err_d  = 1'b1;
            code_d = pred_code;
            exp_d  = pred;
            act_d  = mon_count;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      exp_q   <= '0;
      act_q   <= '0;
      ecnt_q  <= '0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= '{rst: mon_rst, enable: mon_enable, dir: mon_dir};
      cnt_q   <= mon_count;
      err_q   <= err_d;
      code_q  <= code_d;
      exp_q   <= exp_d;
      act_q   <= act_d;
      ecnt_q  <= ecnt_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign err         = err_q;
  assign err_code    = code_q;
  assign exp_at_fail = exp_q;
  assign act_at_fail = act_q;
  assign err_count   = ecnt_q;
  assign chk_count   = ccnt_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a reference model pushes the expected outputs for
// every driven cycle; they are popped and compared one time unit after the edge.
module tb_counter_monitor;

  logic        clk = 1'b0;
  logic        rst, check_en, clear, mon_rst, mon_enable, mon_dir;
  logic [7:0]  mon_count;
  logic        err;
  logic [2:0]  err_code;
  logic [7:0]  exp_at_fail, act_at_fail, err_count;
  logic [15:0] chk_count;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(8), .ERR_CNT_W(8), .CHK_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .check_en(check_en), .clear(clear),
    .mon_rst(mon_rst), .mon_enable(mon_enable), .mon_dir(mon_dir),
    .mon_count(mon_count), .err(err), .err_code(err_code),
    .exp_at_fail(exp_at_fail), .act_at_fail(act_at_fail),
    .err_count(err_count), .chk_count(chk_count)
  );

  typedef struct packed {
    logic        err;
    logic [2:0]  code;
    logic [7:0]  e;
    logic [7:0]  a;
    logic [7:0]  ec;
    logic [15:0] cc;
  } exp_t;

  exp_t       sb[$];
  exp_t       m;
  int         m_st;
  logic       m_r, m_en, m_dir;
  logic [7:0] m_cnt;
  logic [7:0] ctr;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic drive(input logic r, input logic ce, input logic cl,
                       input logic mr, input logic me, input logic md,
                       input logic [7:0] mc);
    logic [7:0] pv;
    logic [2:0] pc;
    logic       mis, act;
    exp_t       got;
    rst = r; check_en = ce; clear = cl;
    mon_rst = mr; mon_enable = me; mon_dir = md; mon_count = mc;
    if (m_r)        begin pv = 8'd0;          pc = 3'd1; end
    else if (!m_en) begin pv = m_cnt;         pc = 3'd2; end
    else if (m_dir) begin pv = m_cnt + 8'd1;  pc = 3'd3; end
    else            begin pv = m_cnt - 8'd1;  pc = 3'd4; end
    mis = (pv != mc);
    act = ce && (m_st >= 2);
    if (r) begin
      m = '0; m_st = 0; m_r = 1'b0; m_en = 1'b0; m_dir = 1'b0; m_cnt = 8'd0;
    end else begin
      if (cl) begin
        m = '0; m_st = 0;
      end else begin
        if (act) begin
          if (m.cc != 16'hFFFF) m.cc = m.cc + 16'd1;
          if (mis) begin
            if (m.ec != 8'hFF) m.ec = m.ec + 8'd1;
            if (!m.err) begin m.err = 1'b1; m.code = pc; m.e = pv; m.a = mc; end
          end
        end
        if (!ce)            m_st = 0;
        else if (m_st == 0) m_st = 1;
        else if (m_st == 1) m_st = 2;
        else if (mis)       m_st = 3;
      end
      m_r = mr; m_en = me; m_dir = md; m_cnt = mc;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("sb_err",       {31'd0, err},    {31'd0, got.err});
    chk("sb_err_code",  {29'd0, err_code}, {29'd0, got.code});
    chk("sb_exp_fail",  {24'd0, exp_at_fail}, {24'd0, got.e});
    chk("sb_act_fail",  {24'd0, act_at_fail}, {24'd0, got.a});
    chk("sb_err_count", {24'd0, err_count},   {24'd0, got.ec});
    chk("sb_chk_count", {16'd0, chk_count},   {16'd0, got.cc});
  endtask

  // One cycle of a well-behaved counter with monitoring on.
  task automatic cstep(input logic mr, input logic me, input logic md);
    drive(1'b0, 1'b1, 1'b0, mr, me, md, ctr);
    if (mr)       ctr = 8'd0;
    else if (!me) ctr = ctr;
    else if (md)  ctr = ctr + 8'd1;
    else          ctr = ctr - 8'd1;
  endtask

  initial begin
    rst = 1'b1; check_en = 1'b0; clear = 1'b0;
    mon_rst = 1'b0; mon_enable = 1'b0; mon_dir = 1'b0; mon_count = 8'd0;
    m = '0; m_st = 0; m_r = 1'b0; m_en = 1'b0; m_dir = 1'b0; m_cnt = 8'd0;
    ctr = 8'd0;

    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_err_count", {24'd0, err_count}, 32'd0);
    chk("reset_chk_count", {16'd0, chk_count}, 32'd0);

    // counting up 0..10: two priming edges, nine compares
    repeat (11) cstep(1'b0, 1'b1, 1'b1);
    chk("up_chk_count", {16'd0, chk_count}, 32'd9);
    chk("up_err", {31'd0, err}, 32'd0);

    // 0,1,2,3,2,1,0,1 through a counter reset
    cstep(1'b1, 1'b1, 1'b1);
    repeat (3) cstep(1'b0, 1'b1, 1'b1);
    repeat (2) cstep(1'b0, 1'b1, 1'b0);
    cstep(1'b1, 1'b1, 1'b0);
    repeat (2) cstep(1'b0, 1'b1, 1'b1);
    chk("updown_err", {31'd0, err}, 32'd0);

    // wrap both ways
    cstep(1'b1, 1'b1, 1'b1);
    cstep(1'b0, 1'b1, 1'b0);
    repeat (2) cstep(1'b0, 1'b1, 1'b1);
    chk("wrap_err", {31'd0, err}, 32'd0);

    // hold fault: prev 5, enable 0, observed 7
    cstep(1'b1, 1'b1, 1'b1);
    repeat (5) cstep(1'b0, 1'b1, 1'b1);
    cstep(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd7);
    ctr = 8'd8;
    chk("hold_err", {31'd0, err}, 32'd1);
    chk("hold_code", {29'd0, err_code}, 32'd2);
    chk("hold_exp", {24'd0, exp_at_fail}, 32'd5);
    chk("hold_act", {24'd0, act_at_fail}, 32'd7);
    chk("hold_err_count", {24'd0, err_count}, 32'd1);

    // second fault after counter reset keeps first capture
    cstep(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    chk("second_code", {29'd0, err_code}, 32'd2);
    chk("second_err_count", {24'd0, err_count}, 32'd2);

    // clear coincident with a third fault drops it
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd9);
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("clear_code", {29'd0, err_code}, 32'd0);
    chk("clear_err_count", {24'd0, err_count}, 32'd0);
    chk("clear_chk_count", {16'd0, chk_count}, 32'd0);
    // back in IDLE: a wild value is only a priming sample
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd77);
    chk("idle_no_cmp", {16'd0, chk_count}, 32'd0);

    // saturation: stuck-at-zero count while counting up
    repeat (302) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("sat_err_count", {24'd0, err_count}, 32'd255);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("disable_keeps_err", {31'd0, err}, 32'd1);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("sat_hold", {24'd0, err_count}, 32'd255);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_err_count", {24'd0, err_count}, 32'd0);
    chk("midrst_chk_count", {16'd0, chk_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
